periph_bus_arbiter: RTL and testbench

- Shares the single-cycle peripheral register port (write enable, address, write data, combinational read data) of the GPIO block, and of any sibling peripherals, between three masters: 0 = core LSU, 1 = debug module, 2 = DMA.
- Registered one-hot grant; one access per grant cycle.
- Optional bus lock lets a master do atomic read-modify-write sequences on gpio_data/gpio_ctrl; a lock timeout keeps the bus from hanging.

---
 rtl/periph_bus_arbiter_if.sv | 59 +++++
 rtl/periph_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_arbiter_if.sv
// Peripheral register-port bundle shared by three masters and one slave.
// The arbiter connects through the slave modport; the masters and the peripheral drive the other side.
interface periph_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              m0_req_i;
  logic              m0_lock_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_gnt_o;
  logic [DATA_W-1:0] m0_rdata_o;

  logic              m1_req_i;
  logic              m1_lock_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_gnt_o;
  logic [DATA_W-1:0] m1_rdata_o;

  logic              m2_req_i;
  logic              m2_lock_i;
  logic              m2_we_i;
  logic [ADDR_W-1:0] m2_addr_i;
  logic [DATA_W-1:0] m2_wdata_i;
  logic              m2_gnt_o;
  logic [DATA_W-1:0] m2_rdata_o;

  logic              s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_wdata_o;
  logic [DATA_W-1:0] s_rdata_i;

  logic              lock_timeout_o;

  // The arbiter's view.
  modport slave (
    input  m0_req_i, m0_lock_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_lock_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m2_req_i, m2_lock_i, m2_we_i, m2_addr_i, m2_wdata_i,
    input  s_rdata_i,
    output m0_gnt_o, m0_rdata_o, m1_gnt_o, m1_rdata_o, m2_gnt_o, m2_rdata_o,
    output s_we_o, s_addr_o, s_wdata_o, lock_timeout_o
  );

  // Requesters plus the peripheral.
  modport master (
    output m0_req_i, m0_lock_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_lock_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m2_req_i, m2_lock_i, m2_we_i, m2_addr_i, m2_wdata_i,
    output s_rdata_i,
    input  m0_gnt_o, m0_rdata_o, m1_gnt_o, m1_rdata_o, m2_gnt_o, m2_rdata_o,
    input  s_we_o, s_addr_o, s_wdata_o, lock_timeout_o
  );

endinterface

// File: rtl/periph_bus_arbiter.sv
// Three-master arbiter for the single-cycle peripheral register port, with bus lock and lock timeout.
// Define PERIPH_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority m0 > m1 > m2 otherwise.
module periph_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  periph_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  state_t            state;
  logic [2:0]        gnt;
  logic [7:0]        lock_cnt;
  logic              lock_timeout;

  logic [2:0]        req;
  logic [2:0]        lock;
  logic [2:0]        we;
  logic [ADDR_W-1:0] addr  [3];
  logic [DATA_W-1:0] wdata [3];

  logic [2:0]        idle_win;
  logic [2:0]        exit_win;
  logic              g_hold;

  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;

  assign req      = {bus.m2_req_i,  bus.m1_req_i,  bus.m0_req_i};
  assign lock     = {bus.m2_lock_i, bus.m1_lock_i, bus.m0_lock_i};
  assign we       = {bus.m2_we_i,   bus.m1_we_i,   bus.m0_we_i};
  assign addr[0]  = bus.m0_addr_i;
  assign addr[1]  = bus.m1_addr_i;
  assign addr[2]  = bus.m2_addr_i;
  assign wdata[0] = bus.m0_wdata_i;
  assign wdata[1] = bus.m1_wdata_i;
  assign wdata[2] = bus.m2_wdata_i;

  // Current grantee still wants the bus and asks to keep it; lock_i of others is ignored.
  assign g_hold = |(gnt & req & lock);

`ifdef PERIPH_ARB_ROUND_ROBIN_EN
  logic [1:0] last_gnt;
  logic [1:0] g_idx;

  // First eligible requester strictly after ptr in circular order 0->1->2->0.
  function automatic logic [2:0] pick(input logic [2:0] elig, input logic [1:0] ptr);
    logic [2:0] win;
    logic [1:0] idx;
    win = '0;
    idx = ptr;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (win == 3'b000 && elig[idx]) win[idx] = 1'b1;
    end
    return win;
  endfunction

  always_comb begin
    g_idx = 2'd0;
    if (gnt[1]) g_idx = 2'd1;
    if (gnt[2]) g_idx = 2'd2;
  end

  assign idle_win = pick(req, last_gnt);
  assign exit_win = pick(req & ~gnt, g_idx);
`else
  function automatic logic [2:0] pick(input logic [2:0] elig);
    logic [2:0] win;
    win = '0;
    if      (elig[0]) win = 3'b001;
    else if (elig[1]) win = 3'b010;
    else if (elig[2]) win = 3'b100;
    return win;
  endfunction

  assign idle_win = pick(req);
  // The master just served is excluded so its current req is never re-granted.
  assign exit_win = pick(req & ~gnt);
`endif

  // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      gnt          <= '0;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
`ifdef PERIPH_ARB_ROUND_ROBIN_EN
      last_gnt     <= 2'd2;
`endif
    end else begin
      lock_timeout <= 1'b0;
`ifdef PERIPH_ARB_ROUND_ROBIN_EN
      if (|gnt) last_gnt <= g_idx;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= idle_win;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (g_hold) begin
            lock_cnt <= 8'd1;
            state    <= LOCK;
          end else begin
            gnt   <= exit_win;
            state <= (|exit_win) ? BUSY : IDLE;
          end
        end
        LOCK: begin
          if (g_hold && lock_cnt != LOCK_MAX_C) begin
            lock_cnt <= lock_cnt + 8'd1;
          end else begin
            // A release with lock still asserted can only be the forced one.
            lock_cnt     <= '0;
            lock_timeout <= g_hold;
            gnt          <= exit_win;
            state        <= (|exit_win) ? BUSY : IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= '0;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      s_we    = s_we    | (gnt[i] & we[i]);
      s_addr  = s_addr  | ({ADDR_W{gnt[i]}} & addr[i]);
      s_wdata = s_wdata | ({DATA_W{gnt[i]}} & wdata[i]);
    end
  end

  assign bus.s_we_o         = s_we;
  assign bus.s_addr_o       = s_addr;
  assign bus.s_wdata_o      = s_wdata;
  assign bus.lock_timeout_o = lock_timeout;

  assign bus.m0_gnt_o   = gnt[0];
  assign bus.m1_gnt_o   = gnt[1];
  assign bus.m2_gnt_o   = gnt[2];
  assign bus.m0_rdata_o = gnt[0] ? bus.s_rdata_i : '0;
  assign bus.m1_rdata_o = gnt[1] ? bus.s_rdata_i : '0;
  assign bus.m2_rdata_o = gnt[2] ? bus.s_rdata_i : '0;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomised and directed bench for periph_bus_arbiter against a grant-sequence reference model.
// A four-register peripheral sits on the slave port so read data and committed writes are observable.
module tb_periph_bus_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  periph_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  periph_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [2:0]  req_v, lock_v, we_v;
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic [31:0] regs    [4];

  assign bus.m0_req_i   = req_v[0];
  assign bus.m1_req_i   = req_v[1];
  assign bus.m2_req_i   = req_v[2];
  assign bus.m0_lock_i  = lock_v[0];
  assign bus.m1_lock_i  = lock_v[1];
  assign bus.m2_lock_i  = lock_v[2];
  assign bus.m0_we_i    = we_v[0];
  assign bus.m1_we_i    = we_v[1];
  assign bus.m2_we_i    = we_v[2];
  assign bus.m0_addr_i  = addr_v[0];
  assign bus.m1_addr_i  = addr_v[1];
  assign bus.m2_addr_i  = addr_v[2];
  assign bus.m0_wdata_i = wdata_v[0];
  assign bus.m1_wdata_i = wdata_v[1];
  assign bus.m2_wdata_i = wdata_v[2];
  assign bus.s_rdata_i  = regs[bus.s_addr_o[3:2]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (bus.s_we_o) begin
      regs[bus.s_addr_o[3:2]] <= bus.s_wdata_o;
    end
  end

  logic [2:0]  dut_gnt;
  logic [31:0] dut_rdata [3];
  assign dut_gnt      = {bus.m2_gnt_o, bus.m1_gnt_o, bus.m0_gnt_o};
  assign dut_rdata[0] = bus.m0_rdata_o;
  assign dut_rdata[1] = bus.m1_rdata_o;
  assign dut_rdata[2] = bus.m2_rdata_o;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus this cycle and for how many consecutive cycles.
  int own;
  int run;
  int cur;
  bit exp_to;
`ifdef PERIPH_ARB_ROUND_ROBIN_EN
  int last;
`endif

  task automatic reset_model();
    own    = -1;
    run    = 0;
    exp_to = 1'b0;
`ifdef PERIPH_ARB_ROUND_ROBIN_EN
    last   = 2;
`endif
  endtask

  // Decide the owner of the next cycle from the current owner and the inputs before the edge.
  task automatic step();
    int  nxt;
    int  start;
    bit  hold;
    nxt    = -1;
    exp_to = 1'b0;
    hold   = (own >= 0) && req_v[own] && lock_v[own];
    if (hold && run <= LOCK_MAX) begin
      nxt = own;
    end else begin
`ifdef PERIPH_ARB_ROUND_ROBIN_EN
      start = (((own < 0) ? last : own) + 1) % 3;
`else
      start = 0;
`endif
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (start + k) % 3;
        if (nxt < 0 && req_v[i] && i != own) nxt = i;
      end
      exp_to = hold;
    end
`ifdef PERIPH_ARB_ROUND_ROBIN_EN
    if (own >= 0) last = own;
`endif
    if (nxt >= 0 && nxt == own) run = run + 1;
    else if (nxt >= 0)          run = 1;
    else                        run = 0;
    own = nxt;
  endtask

  task automatic check_outputs();
    logic [31:0] ea;
    cur = own;
    ea  = (own >= 0) ? addr_v[own] : 32'h0;
    check("gnt",     dut_gnt,       (own >= 0) ? (3'b001 << own) : 3'b000);
    check("s_we",    bus.s_we_o,    (own >= 0) ? we_v[own] : 1'b0);
    check("s_addr",  bus.s_addr_o,  ea);
    check("s_wdata", bus.s_wdata_o, (own >= 0) ? wdata_v[own] : 32'h0);
    for (int i = 0; i < 3; i++)
      check($sformatf("m%0d_rdata", i), dut_rdata[i], (own == i) ? regs[ea[3:2]] : 32'h0);
    check("lock_timeout", bus.lock_timeout_o, exp_to);
  endtask

  // Check this cycle at the falling edge, advance the model, land just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_v  = '0;
    lock_v = '0;
    we_v   = '0;
    for (int i = 0; i < 3; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
  endtask

  int m1_run, pulses, prev;
  bit m1_seen, m1_done;

  initial begin
    rst = 1'b0;
    clear_inputs();
    reset_model();
    #7;
    check_outputs();
    #5 rst = 1'b1;
    @(posedge clk);
    #1;

    // Single write from m1: grant exactly one cycle after req, write visible on the slave port.
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h4; wdata_v[1] = 32'h3;
    tick();
    tick();
    clear_inputs();
    tick();
    check("reg4_after_write", regs[1], 32'h3);

    // All three request together from IDLE; each drops req once served.
    req_v = 3'b111; we_v = 3'b111;
    for (int i = 0; i < 3; i++) begin
      addr_v[i]  = 32'h8 + 32'(4 * i);
      wdata_v[i] = 32'hA0 + 32'(i);
    end
    for (int n = 0; n < 5; n++) begin
      tick();
      if (cur >= 0) req_v[cur] = 1'b0;
    end
    clear_inputs();

    // m2 locked read-modify-write of 0x4 while m0 keeps requesting.
    req_v[2] = 1'b1; lock_v[2] = 1'b1; addr_v[2] = 32'h4;
    tick();
    req_v[0] = 1'b1; addr_v[0] = 32'h0;
    tick();
    we_v[2] = 1'b1; wdata_v[2] = 32'h5; lock_v[2] = 1'b0;
    tick();
    req_v[2] = 1'b0; we_v[2] = 1'b0;
    tick();
    req_v[0] = 1'b0;
    tick();
    check("reg4_after_rmw", regs[1], 32'h5);

    // m1 holds lock past LOCK_MAX; m0 waiting.
    clear_inputs();
    req_v[1] = 1'b1; lock_v[1] = 1'b1; addr_v[1] = 32'hC;
    m1_run = 0; pulses = 0; m1_seen = 1'b0; m1_done = 1'b0;
    for (int n = 0; n < 24; n++) begin
      tick();
      req_v[0] = 1'b1;
      if (bus.lock_timeout_o) pulses++;
      if (bus.m1_gnt_o && !m1_done) begin m1_seen = 1'b1; m1_run++; end
      else if (m1_seen) m1_done = 1'b1;
    end
    check("m1_lock_run_len", m1_run, LOCK_MAX + 1);
    check("timeout_pulses", pulses, 1);
    clear_inputs();
    tick();
    tick();

    // Asynchronous reset in the middle of a lock.
    req_v[0] = 1'b1; lock_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h8; wdata_v[0] = 32'h77;
    for (int n = 0; n < 5; n++) tick();
    #3 rst = 1'b0;
    #1;
    check("rst_gnt",    dut_gnt, 3'b000);
    check("rst_s_we",   bus.s_we_o, 1'b0);
    check("rst_s_addr", bus.s_addr_o, 32'h0);
    check("rst_m0_rdata", dut_rdata[0], 32'h0);
    clear_inputs();
    reset_model();
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    req_v[2] = 1'b1; addr_v[2] = 32'h4;
    tick();
    tick();
    clear_inputs();
    tick();

    // m0 and m1 re-requesting continuously: m0 never served twice in a row.
    req_v = 3'b011; addr_v[0] = 32'h0; addr_v[1] = 32'h4;
    prev = -1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (prev == 0 && cur == 0) check("m0_twice", 1, 0);
      prev = cur;
    end
    clear_inputs();
    tick();

    // Random traffic; the current owner usually keeps req and lock so timeouts occur.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        req_v[i]   = ($urandom_range(0, 99) < 55);
        lock_v[i]  = ($urandom_range(0, 99) < 70);
        we_v[i]    = $urandom_range(0, 1) == 1;
        addr_v[i]  = $urandom & 32'hFFFF_FFFC;
        wdata_v[i] = $urandom;
      end
      if (own >= 0 && $urandom_range(0, 9) != 0) begin
        req_v[own]  = 1'b1;
        lock_v[own] = 1'b1;
      end
      tick();
    end
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
